// File: rtl/quick_spi.sv
// quick_spi: single-byte-command SPI master, mode 0 (CPOL=0, CPHA=0).
//
// A transaction is accepted from IDLE on one clk edge (E0). On the following
// 32 edges (E1..E32) sclk runs at clk/2 and 16 bits are exchanged MSB first.
// A write shifts all 16 bits of the latched outgoing word. A read shifts the
// upper byte, then drives mosi low while the slave's reply byte is sampled
// from miso. Edge E32 closes the frame and pulses end_of_transaction.
//
// Build option:
//   QUICK_SPI_READ_EN - when defined, operation=1 selects a read. When
//                       undefined, every transaction is a write and
//                       incoming_data stays 8'h00.
//
// Reset is synchronous and active-low (rst_n), and it wins over every
// other condition.

module quick_spi (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        start_transaction,
  input  logic [1:0]  slave,
  input  logic        operation,
  input  logic [15:0] outgoing_data,
  input  logic        miso,
  output logic        end_of_transaction,
  output logic [7:0]  incoming_data,
  output logic        mosi,
  output logic        sclk,
  output logic [1:0]  ss_n
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // edge_cnt holds (k-1) just before ACTIVE edge E_k.
  // The value 31 therefore marks E32, the closing edge.
  localparam logic [4:0] LAST_EDGE  = 5'd31;
  // From E16 onward a read drives mosi low (bits 9..16 of the frame).
  localparam logic [4:0] RD_ZERO_AT = 5'd15;
  // From E17 onward a read samples miso on rising sclk edges.
  localparam logic [4:0] RD_SAMP_AT = 5'd16;

  state_t      state;
  logic [4:0]  edge_cnt;
  logic [15:0] tx_shift;
  logic [7:0]  rx_shift;
  logic        read_q;
  logic        read_req;

`ifdef QUICK_SPI_READ_EN
  // Read support: the operation input selects write (0) or read (1).
  assign read_req = operation;
`else
  // Write-only build: operation has no effect.
  assign read_req = 1'b0;
  logic unused_operation;
  assign unused_operation = operation;
`endif

  // Transaction FSM. It also generates sclk, mosi and ss_n and shifts the
  // data, so every output comes straight from a register.
  always_ff @(posedge clk) begin
    // NOTE: state and outputs are written with <= so that every right-hand
    // side sees the values from before this edge, which is exactly what the
    // shift registers and the sclk toggle rely on.
    if (!rst_n) begin
      state              <= IDLE;
      edge_cnt           <= '0;
      tx_shift           <= '0;
      rx_shift           <= '0;
      read_q             <= 1'b0;
      sclk               <= 1'b0;
      mosi               <= 1'b0;
      ss_n               <= 2'b11;
      end_of_transaction <= 1'b0;
      incoming_data      <= 8'h00;
    end else begin
      // NOTE: end_of_transaction defaults low on every edge. Only the
      // closing edge raises it, so it can never last more than one cycle.
      end_of_transaction <= 1'b0;

      unique case (state)
        IDLE: begin
          sclk     <= 1'b0;
          mosi     <= 1'b0;
          ss_n     <= 2'b11;
          edge_cnt <= '0;
          // A request with no slave selected is ignored.
          if (enable && start_transaction && (slave != 2'b00)) begin
            state    <= ACTIVE;
            ss_n     <= ~slave;
            mosi     <= outgoing_data[15];
            tx_shift <= outgoing_data;
            rx_shift <= '0;
            read_q   <= read_req;
          end
        end

        ACTIVE: begin
          if (!enable) begin
            // Abort: drop the frame at once. There is no completion pulse,
            // and incoming_data keeps its last value.
            state    <= IDLE;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            ss_n     <= 2'b11;
            edge_cnt <= '0;
          end else if (edge_cnt == LAST_EDGE) begin
            // E32: the last falling sclk edge closes the frame.
            state              <= IDLE;
            sclk               <= 1'b0;
            mosi               <= 1'b0;
            ss_n               <= 2'b11;
            edge_cnt           <= '0;
            end_of_transaction <= 1'b1;
            if (read_q) begin
              incoming_data <= rx_shift;
            end
          end else begin
            edge_cnt <= edge_cnt + 5'd1;
            sclk     <= ~sclk;
            if (!sclk) begin
              // Rising sclk edge: the slave samples mosi here. During the
              // data phase of a read, the master captures miso.
              if (read_q && (edge_cnt >= RD_SAMP_AT)) begin
                rx_shift <= {rx_shift[6:0], miso};
              end
            end else begin
              // Falling sclk edge: present the next bit on mosi.
              tx_shift <= {tx_shift[14:0], 1'b0};
              mosi     <= (read_q && (edge_cnt >= RD_ZERO_AT)) ? 1'b0 : tx_shift[14];
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_quick_spi.sv
// Self-checking bench for quick_spi.
//
// A transaction-level model predicts every output on every cycle from the
// latched request and the edge index k since acceptance. Directed sequences
// pin that model to literal values, and a randomized phase exercises the
// remaining cases. The bench builds with or without QUICK_SPI_READ_EN, and
// the model follows the same setting.

module tb_quick_spi;

`ifdef QUICK_SPI_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        start_transaction;
  logic [1:0]  slave;
  logic        operation;
  logic [15:0] outgoing_data;
  logic        miso;
  logic        end_of_transaction;
  logic [7:0]  incoming_data;
  logic        mosi;
  logic        sclk;
  logic [1:0]  ss_n;

  int n_checks = 0;
  int n_pass   = 0;

  quick_spi dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .enable             (enable),
    .start_transaction  (start_transaction),
    .slave              (slave),
    .operation          (operation),
    .outgoing_data      (outgoing_data),
    .miso               (miso),
    .end_of_transaction (end_of_transaction),
    .incoming_data      (incoming_data),
    .mosi               (mosi),
    .sclk               (sclk),
    .ss_n               (ss_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit        model_valid = 1'b0;
  bit        m_active;
  int        m_k;
  bit [1:0]  m_slave;
  bit        m_read;
  bit [15:0] m_data;
  bit [7:0]  m_rx;
  bit [7:0]  m_inc;
  bit        m_eot;

  task automatic model_step();
    m_eot = 1'b0;
    if (!rst_n) begin
      m_active = 1'b0;
      m_k      = 0;
      m_inc    = 8'h00;
    end else if (!m_active) begin
      if (enable && start_transaction && slave != 2'b00) begin
        m_active = 1'b1;
        m_k      = 0;
        m_slave  = slave;
        m_read   = READ_EN && operation;
        m_data   = outgoing_data;
        m_rx     = 8'h00;
      end
    end else if (!enable) begin
      m_active = 1'b0;
    end else begin
      m_k++;
      // Reply bits come on odd edges E17..E31, MSB first.
      if (m_read && m_k >= 17 && (m_k % 2) == 1) m_rx[7 - (m_k - 17) / 2] = miso;
      if (m_k == 32) begin
        m_active = 1'b0;
        m_eot    = 1'b1;
        if (m_read) m_inc = m_rx;
      end
    end
    model_valid = 1'b1;
  endtask

  function automatic logic [12:0] model_outputs();
    logic [1:0] e_ss;
    logic       e_sclk;
    logic       e_mosi;
    int         b;
    b      = m_k / 2;
    e_ss   = m_active ? ~m_slave : 2'b11;
    e_sclk = m_active && (m_k % 2) == 1;
    e_mosi = m_active && !(m_read && b >= 8) && m_data[15 - b];
    return {m_eot, m_inc, e_mosi, e_sclk, e_ss};
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (model_valid)
        check("cycle_outputs",
              32'({end_of_transaction, incoming_data, mosi, sclk, ss_n}),
              32'(model_outputs()));
    end
  end

  // ---------------- directed transaction driver ----------------
  task automatic do_txn(input logic [1:0] slv, input logic op, input logic [15:0] data,
                        input logic [7:0] sbyte, input int abort_at, input int rst_at,
                        output logic [15:0] cap, output int eot_c, output logic [1:0] ss_first);
    @(negedge clk);
    enable            = 1'b1;
    start_transaction = 1'b1;
    slave             = slv;
    operation         = op;
    outgoing_data     = data;
    @(negedge clk);
    // E0 has happened. Scramble the inputs: the latched values must be used.
    start_transaction = 1'b0;
    slave             = 2'($urandom);
    operation         = 1'($urandom);
    outgoing_data     = 16'($urandom);
    cap      = 16'h0000;
    eot_c    = -1;
    ss_first = 2'b00;
    for (int c = 1; c <= 36; c++) begin
      miso = (c >= 17 && (c % 2) == 1) ? sbyte[7 - (c - 17) / 2] : 1'($urandom);
      if (c == abort_at) enable = 1'b0;
      if (c == rst_at) rst_n = 1'b0;
      @(negedge clk);
      if (c == 1) ss_first = ss_n;
      if (sclk) cap = {cap[14:0], mosi};
      if (end_of_transaction && eot_c < 0) eot_c = c;
      if (c == abort_at - 1) check("pre_abort_sclk", 32'(sclk), 32'(1));
      if (c == abort_at) begin
        check("abort_sclk_ss", 32'({sclk, ss_n, mosi}), 32'({1'b0, 2'b11, 1'b0}));
        enable = 1'b1;
      end
      if (c == rst_at) begin
        check("mid_reset_outputs",
              32'({end_of_transaction, incoming_data, mosi, sclk, ss_n}),
              32'({1'b0, 8'h00, 1'b0, 1'b0, 2'b11}));
        rst_n = 1'b1;
      end
    end
  endtask

  logic [15:0] cap;
  int          eot_c;
  logic [1:0]  ss_first;
  int          eots[$];
  int          ss_idle_cnt;

  initial begin
    rst_n             = 1'b0;
    enable            = 1'b0;
    start_transaction = 1'b0;
    slave             = 2'b00;
    operation         = 1'b0;
    outgoing_data     = 16'h0000;
    miso              = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          32'({end_of_transaction, incoming_data, mosi, sclk, ss_n}),
          32'({1'b0, 8'h00, 1'b0, 1'b0, 2'b11}));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write 16'h5A6A to slave 0.
    do_txn(2'b01, 1'b0, 16'h5A6A, 8'h00, 0, 0, cap, eot_c, ss_first);
    check("wr_ss_n", 32'(ss_first), 32'(2'b10));
    check("wr_mosi_bits", 32'(cap), 32'(16'h5A6A));
    check("wr_eot_latency", 32'(eot_c), 32'(32));
    check("wr_incoming", 32'(incoming_data), 32'(8'h00));

    // Read with reply byte 8'h95.
    do_txn(2'b01, 1'b1, 16'h5A6A, 8'h95, 0, 0, cap, eot_c, ss_first);
    check("rd_mosi_bits", 32'(cap), READ_EN ? 32'(16'h5A00) : 32'(16'h5A6A));
    check("rd_incoming", 32'(incoming_data), READ_EN ? 32'(8'h95) : 32'(8'h00));
    check("rd_eot_latency", 32'(eot_c), 32'(32));

    // Second read: other slave, other pattern.
    do_txn(2'b10, 1'b1, 16'hC3A5, 8'h3C, 0, 0, cap, eot_c, ss_first);
    check("rd2_ss_n", 32'(ss_first), 32'(2'b01));
    check("rd2_mosi_bits", 32'(cap), READ_EN ? 32'(16'hC300) : 32'(16'hC3A5));
    check("rd2_incoming", 32'(incoming_data), READ_EN ? 32'(8'h3C) : 32'(8'h00));

    // Abort at E10: no pulse, incoming_data kept.
    do_txn(2'b11, 1'b1, 16'hFFFF, 8'hA5, 10, 0, cap, eot_c, ss_first);
    check("abort_no_eot", 32'(eot_c), 32'(-1));
    check("abort_incoming_kept", 32'(incoming_data), READ_EN ? 32'(8'h3C) : 32'(8'h00));

    // slave=2'b00 request is ignored.
    @(negedge clk);
    enable            = 1'b1;
    start_transaction = 1'b1;
    slave             = 2'b00;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("no_slave_idle", 32'({end_of_transaction, sclk, ss_n}), 32'({1'b0, 1'b0, 2'b11}));
    end
    start_transaction = 1'b0;

    // Back-to-back with start held high, operation toggled at each pulse.
    @(negedge clk);
    start_transaction = 1'b1;
    slave             = 2'b11;
    operation         = 1'b0;
    outgoing_data     = 16'h1234;
    ss_idle_cnt       = 0;
    for (int c = 0; c < 120; c++) begin
      miso = 1'($urandom);
      @(negedge clk);
      if (end_of_transaction) begin
        eots.push_back(c);
        operation = ~operation;
      end
      if (eots.size() == 1 && ss_n == 2'b11) ss_idle_cnt++;
    end
    start_transaction = 1'b0;
    check("b2b_pulse_count", 32'(eots.size()), 32'(3));
    if (eots.size() >= 3) begin
      check("b2b_first_pulse", 32'(eots[0]), 32'(32));
      check("b2b_period_1", 32'(eots[1] - eots[0]), 32'(33));
      check("b2b_period_2", 32'(eots[2] - eots[1]), 32'(33));
    end
    check("b2b_ss_gap", 32'(ss_idle_cnt), 32'(1));
    repeat (40) @(negedge clk);

    // Reset at E20 of a read.
    do_txn(2'b01, 1'b1, 16'h5A6A, 8'h95, 0, 20, cap, eot_c, ss_first);
    check("reset_no_eot", 32'(eot_c), 32'(-1));

    // Randomized phase.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst_n             = ($urandom_range(0, 299) != 0);
      enable            = ($urandom_range(0, 59) != 0);
      start_transaction = ($urandom_range(0, 3) == 0);
      slave             = 2'($urandom);
      operation         = 1'($urandom);
      outgoing_data     = 16'($urandom);
      miso              = 1'($urandom);
    end
    @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b1;
    start_transaction = 1'b0;
    repeat (40) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/quick_spi.md
QUICK_SPI -- requirements
Module: quick_spi

Interface
REQ-001 Parameter: none; all widths fixed as listed below.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 enable  input  1  block enable; low forces/keeps IDLE.
REQ-005 start_transaction  input  1  request; accepted in IDLE when enable=1.
REQ-006 slave  input  2  slave select mask; bit i=1 selects slave i.
REQ-007 operation  input  1  0=write, 1=read.
REQ-008 outgoing_data  input  16  transmit word, MSB first.
REQ-009 miso  input  1  serial data from slave.
REQ-010 end_of_transaction  output  1  one-cycle pulse on normal completion.
REQ-011 incoming_data  output  8  last received read byte.
REQ-012 mosi  output  1  serial data to slave.
REQ-013 sclk  output  1  SPI clock, mode 0 (CPOL=0, CPHA=0), idles 0.
REQ-014 ss_n  output  2  active-low slave selects; ss_n = ~slave latched while active, 2'b11 otherwise.

Function
REQ-015 States: IDLE, ACTIVE; all outputs registered.
REQ-016 IDLE accepts on edge E0 when enable=1, start_transaction=1, slave!=0; latches slave, operation, outgoing_data; drives ss_n=~slave, sclk=0, mosi=outgoing_data[15]; enters ACTIVE.
REQ-017 Request with slave=2'b00 is ignored; block stays IDLE.
REQ-018 ACTIVE: sclk toggles on every clk edge E1..E32 (sclk = clk/2); rising on odd edges, falling on even edges; 16 rising edges total.
REQ-019 mosi changes only on edges that drive sclk low (E2..E30); bit order outgoing bit 15 down to 0.
REQ-020 Write: all 16 bits of latched outgoing_data shifted out; incoming_data unchanged.
REQ-021 Read: bits 15..8 shifted out for first 8 bits, then mosi=0 for remaining 8 bits; miso sampled on edges driving sclk high for bits 9..16 (E17,E19,...,E31), MSB first.
REQ-022 At E32: sclk=0, ss_n=2'b11, mosi=0, end_of_transaction=1 for exactly one cycle, incoming_data updated (read only), state->IDLE.
REQ-023 New request earliest at E33; ss_n high for at least one cycle between transactions; start_transaction held high gives back-to-back transactions every 33 cycles.
REQ-024 Input changes during ACTIVE are ignored (latched values used).
REQ-025 enable=0 during ACTIVE aborts on the next edge: IDLE, sclk=0, ss_n=2'b11, mosi=0, no end_of_transaction, incoming_data unchanged.

Reset
REQ-026 rst_n=0 at any edge, including mid-transaction: state=IDLE, sclk=0, mosi=0, ss_n=2'b11, end_of_transaction=0, incoming_data=8'h00, counters cleared.
REQ-027 Reset has priority over every other condition.

Configuration
REQ-028 Macro QUICK_SPI_READ_EN defined: read operation supported per REQ-021.
REQ-029 Macro QUICK_SPI_READ_EN undefined: operation ignored, every transaction is a write, miso unused, incoming_data constant 8'h00.

Verification
REQ-030 Write: slave=2'b01, operation=0, outgoing_data=16'h5A6A -> ss_n=2'b10, mosi on rising sclk = 0101101001101010, end_of_transaction pulse 32 cycles after acceptance edge.
REQ-031 Read (macro defined): outgoing_data=16'h5A6A, slave drives 8'h95 MSB first in data phase -> mosi 01011010 then 00000000, incoming_data=8'h95 with end_of_transaction.
REQ-032 start_transaction held 1, operation toggled at each end_of_transaction -> alternating write/read, 33-cycle period, ss_n=2'b11 for one cycle between.
REQ-033 enable dropped at E10 -> next edge sclk=0, ss_n=2'b11, no end_of_transaction pulse.
REQ-034 slave=2'b00 with start -> ss_n stays 2'b11, sclk stays 0, no pulse.
REQ-035 rst_n=0 at E20 of a read -> all outputs at reset values on that edge; incoming_data=8'h00.
